// File: rtl/rv_dmem_ctrl_if.sv
// Request/response bundle between the Q103H memory stage and the data-memory
// controller. The package carries the request struct shared by both ends.
// Ports: master drives the request and sees ready/read data/fault; slave is the reverse.

package rv_dmem_pkg;
  typedef struct packed {
    logic [31:0] address;
    logic [31:0] wr_data;   // lane-aligned
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  byte_en;
  } t_core2mem_req;
endpackage

interface rv_dmem_ctrl_if;
  import rv_dmem_pkg::*;

  t_core2mem_req core2dmem_req_Q103H;
  logic          dmem_ready_Q103H;
  logic [31:0]   dmem_rd_data_Q104H;
  logic          dmem_fault_Q104H;

  modport master (
    output core2dmem_req_Q103H,
    input  dmem_ready_Q103H,
    input  dmem_rd_data_Q104H,
    input  dmem_fault_Q104H
  );

  modport slave (
    input  core2dmem_req_Q103H,
    output dmem_ready_Q103H,
    output dmem_rd_data_Q104H,
    output dmem_fault_Q104H
  );
endinterface

// File: rtl/rv_dmem_ctrl.sv
// Word-organised data memory with byte write enables and WAIT_STATES stall cycles
// per access; stalls Q103H via ready and returns registered full-word data at Q104H.
// Ports: clk, rst (sync, active-high), bus (slave side of rv_dmem_ctrl_if).

module rv_dmem_ctrl
  import rv_dmem_pkg::*;
#(
  parameter logic [31:0] DMEM_BASE       = 32'h0000_2000,
  parameter int          DMEM_SIZE_WORDS = 1024,
  parameter int          WAIT_STATES     = 0
) (
  input  logic           clk,
  input  logic           rst,
  rv_dmem_ctrl_if.slave  bus
);

  localparam int          IDX_W    = $clog2(DMEM_SIZE_WORDS);
  // 33-bit end address so a region touching 4 GiB does not wrap.
  localparam logic [32:0] DMEM_END = {1'b0, DMEM_BASE} + 33'(DMEM_SIZE_WORDS) * 33'd4;
  localparam logic [3:0]  CNT_INIT = 4'(WAIT_STATES - 1);
  localparam bit          HAS_WAIT = (WAIT_STATES != 0);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  t_core2mem_req req_s;
  logic          req;
  logic          ready;
  logic          complete;
  logic          in_range;
  logic [31:0]   offset;
  logic [IDX_W-1:0] idx;
  logic [31:0]   rd_data;
  logic          fault;
  logic [31:0]   mem [DMEM_SIZE_WORDS];

  assign req_s    = bus.core2dmem_req_Q103H;
  assign req      = req_s.wr_en | req_s.rd_en;
  assign in_range = (req_s.address >= DMEM_BASE) && ({1'b0, req_s.address} < DMEM_END);
  assign offset   = req_s.address - DMEM_BASE;
  assign idx      = offset[IDX_W+1:2];

  // Byte offset within the word and bits above the memory depth are don't-care.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{offset[31:IDX_W+2], offset[1:0]};

  always_comb begin
    ready     = 1'b1;
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req && HAS_WAIT) begin
          ready     = 1'b0;
          state_nxt = BUSY;
          cnt_nxt   = CNT_INIT;
        end
      end
      BUSY: begin
        if (!req) begin
          // Request withdrawn (flush): release the stage, no access.
          state_nxt = IDLE;
        end else if (cnt != 4'd0) begin
          ready   = 1'b0;
          cnt_nxt = cnt - 4'd1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      ready = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Ready is forced high in reset, so reset must also veto the access itself.
  assign complete = req & ready & ~rst;

  // Memory has no reset so it can map onto a RAM macro.
  always_ff @(posedge clk) begin
    if (complete && req_s.wr_en && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (req_s.byte_en[i]) begin
          mem[idx][8*i +: 8] <= req_s.wr_data[8*i +: 8];
        end
      end
    end
  end

  // A simultaneous wr_en/rd_en is treated as a write: read data holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= 32'd0;
      fault   <= 1'b0;
    end else begin
      fault <= 1'b0;
      if (complete) begin
        if (!in_range) begin
          fault <= 1'b1;
          if (req_s.rd_en && !req_s.wr_en) begin
            rd_data <= 32'd0;
          end
        end else if (req_s.rd_en && !req_s.wr_en) begin
          rd_data <= mem[idx];
        end
      end
    end
  end

  assign bus.dmem_ready_Q103H   = ready;
  assign bus.dmem_rd_data_Q104H = rd_data;
  assign bus.dmem_fault_Q104H   = fault;

endmodule

// File: doc/rv_dmem_ctrl.md
# rv_dmem_ctrl

Data-memory controller consuming the Q103H memory-access request and producing the Q104H read data for write-back. It holds a word-organised data memory with per-byte write enables and a configurable number of wait states. It drives a ready signal that stalls the Q103H stage until the access completes. Load alignment and sign extension are out of scope; they belong to the write-back stage.

## Interface
- `DMEM_BASE`, default 32'h0000_2000: byte address of word 0.
- `DMEM_SIZE_WORDS`, default 1024: memory depth in 32-bit words; must be a power of 2.
- `WAIT_STATES`, default 0: number of stall cycles per access; range 0..15.

Ports:
- `clk`  input  1  core clock; the only clock.
- `rst`  input  1  synchronous, active-high reset.
- `core2dmem_req_Q103H`  input  t_core2mem_req  request struct with the following fields:
  - `address[31:0]`
  - `wr_data[31:0]`, lane-aligned
  - `wr_en`
  - `rd_en`
  - `byte_en[3:0]`
- `dmem_ready_Q103H`  output  1  when 1, the Q103H stage may advance at the next edge; when 0, the stage holds.
- `dmem_rd_data_Q104H`  output  32  registered full-word read data.
- `dmem_fault_Q104H`  output  1  registered one-cycle pulse for an out-of-range completed access.

## Operation
- **Request valid:** `req = wr_en | rd_en`.
- **Range check:** in range iff `DMEM_BASE <= address < DMEM_BASE + 4*DMEM_SIZE_WORDS`.
- **Word index:** `(address - DMEM_BASE) >> 2`. `address[1:0]` is ignored.
- **FSM states:** IDLE and BUSY, plus a down-counter `cnt` of 4 bits.
  - IDLE, `!req`: `ready = 1`; no access.
  - IDLE, `req`, `WAIT_STATES == 0`: `ready = 1`; the access completes this cycle.
  - IDLE, `req`, `WAIT_STATES > 0`: `ready = 0`; next state is BUSY with `cnt <= WAIT_STATES-1`.
  - BUSY, `req`, `cnt != 0`: `ready = 0`; `cnt <= cnt-1`.
  - BUSY, `req`, `cnt == 0`: `ready = 1`; the access completes; next state is IDLE.
  - BUSY, `!req` (request withdrawn or flushed): `ready = 1`; next state is IDLE; no access is performed.
- **Completing access:** `req & ready` in the current cycle.
- **Write:** on a completing access with `wr_en` in range, bits [8i+7:8i] of the addressed word are written for each i where `byte_en[i]` = 1. Other lanes are unchanged. `byte_en` = 0 is a legal no-op.
- **Read:** on a completing access with `rd_en` in range, `dmem_rd_data_Q104H <= mem[idx]` at that edge. At all other times `dmem_rd_data_Q104H` holds its value.
- **Out of range:** on a completing out-of-range access, writes are dropped, `dmem_rd_data_Q104H <= 0` if `rd_en`, and `dmem_fault_Q104H <= 1` for one cycle. Otherwise `dmem_fault_Q104H <= 0` every cycle.
- **wr_en & rd_en together:** illegal from the decoder. The block performs the write only; read data holds.
- **Reset:**
  - state = IDLE, `cnt` = 0, `dmem_rd_data_Q104H` = 0, `dmem_fault_Q104H` = 0.
  - `dmem_ready_Q103H` is forced to 1 while `rst` is high.
  - Memory contents are not reset.
  - Reset during BUSY discards the pending access; no write occurs.

## Timing
- `dmem_ready_Q103H` is combinational from state, `cnt` and `req`; there is no combinational path from `address` or `wr_data`.
- Stall length per access is exactly `WAIT_STATES` cycles of `ready = 0`, then 1 cycle of `ready = 1`.
- Read data is valid in the cycle after the completing edge, at Q104H.
- **Back-to-back accesses:**
  - After a completion, the next request is presented in the following cycle and sees IDLE.
  - No idle bubble is inserted beyond `WAIT_STATES`.
  - With `WAIT_STATES == 0`, throughput is 1 access per cycle.
- **Read-after-write:** a read in the cycle after a write to the same word returns the new data. The write commits at the earlier edge.
- The request must be held stable while `ready` = 0; a changed request in BUSY other than withdrawal is undefined.

## Test plan
1. `WAIT_STATES=0`: write 32'hDEAD_BEEF to 0x2004 with `byte_en`=4'hF, then read 0x2004 -> `ready` stays 1; `rd_data_Q104H` = 32'hDEAD_BEEF one cycle after the read.
2. Byte lanes: write 32'h0000_AA00 to 0x2004 with `byte_en`=4'b0010 over word 32'hDEAD_BEEF, then read -> 32'hDEAD_AAEF.
3. `WAIT_STATES=3`: a read is held -> `ready` = 0 for exactly 3 cycles, 1 on the 4th; data appears in the 5th; a back-to-back second read repeats the 3-cycle stall.
4. Out of range: read 0x1FFC, then write 0x3000 (`SIZE`=1024) -> `rd_data` = 0 and `fault` pulses 1 for each access; memory is unchanged (read back 0x2FFC intact).
5. `WAIT_STATES=3`: assert `rst` in the 2nd BUSY cycle of a write -> `ready` = 1, state IDLE, `rd_data` = 0, `fault` = 0; the target word is unchanged.
6. `WAIT_STATES=3`: drop `wr_en` in BUSY (flush) -> `ready` = 1 the same cycle, FSM returns to IDLE, and no write occurs.
